// File: rtl/uop_logic_pkg.sv
// Shared types and constants for the pipelined bitwise logic unit.
package uop_logic_pkg;

  typedef enum logic [2:0] {
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NAND,
    OP_NOR,
    OP_XNOR,
    OP_PASS_A,
    OP_NOT_A
  } logic_op_t;

  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 8;

endpackage

// File: rtl/uop_pipe_stage.sv
// One pipeline stage: a valid bit plus a data word, loaded together on enable.
module uop_pipe_stage
  import uop_logic_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/uop_logic_pipe.sv
// Two-operand bitwise logic unit with a fixed-latency valid/ready pipeline.
module uop_logic_pipe
  import uop_logic_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic_op_t        op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("uop_logic_pipe: LATENCY out of range");
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("uop_logic_pipe: WIDTH out of range");
  end

  logic [WIDTH-1:0] w_op_res;
  logic             w_adv;
  logic [LATENCY:0] w_vld;
  logic [WIDTH-1:0] w_dat [LATENCY+1];

  always_comb begin
    w_op_res = '0;
    case (op)
      OP_AND:    w_op_res = a & b;
      OP_OR:     w_op_res = a | b;
      OP_XOR:    w_op_res = a ^ b;
      OP_NAND:   w_op_res = ~(a & b);
      OP_NOR:    w_op_res = ~(a | b);
      OP_XNOR:   w_op_res = ~(a ^ b);
      OP_PASS_A: w_op_res = a;
      OP_NOT_A:  w_op_res = ~a;
      default:   w_op_res = '0;
    endcase
  end

  // Index 0 is the combinational input; indices 1..LATENCY are stage outputs.
  assign w_vld[0] = in_valid;
  assign w_dat[0] = w_op_res;

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    uop_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .n_reset (n_reset),
      .i_en    (w_adv),
      .i_valid (w_vld[i]),
      .i_data  (w_dat[i]),
      .o_valid (w_vld[i+1]),
      .o_data  (w_dat[i+1])
    );
  end

  // Single global enable: bubbles are not collapsed, the whole pipe moves or holds.
  assign w_adv     = !out_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = w_vld[LATENCY];
  assign result    = w_dat[LATENCY];
  assign busy      = |w_vld[LATENCY:1];

endmodule

// File: tb/tb_uop_logic_pipe.sv
// Scoreboard bench for uop_logic_pipe at 8/2, 1/1 and 64/8 width/latency.
module tb_uop_logic_pipe;
  import uop_logic_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              n_reset;
  logic [2:0]        iv, ordy, irdy, ov, bsy;
  logic [2:0][2:0]   opv;
  logic [2:0][63:0]  av, bv;
  logic [7:0]        res0;
  logic [0:0]        res1;
  logic [63:0]       res2;
  logic [63:0]       robs [3];

  typedef struct {
    logic [63:0] res;
    int          cyc;
    bit          exact;
  } ent_t;

  ent_t        sb [3][$];
  int unsigned lat [3] = '{2, 1, 8};
  int unsigned wid [3] = '{8, 1, 64};
  bit          exact_mode [3];
  bit          prev_stall [3];
  logic [63:0] prev_res [3];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  uop_logic_pipe #(.WIDTH(8), .LATENCY(2)) u_dut0 (
    .clk(clk), .n_reset(n_reset), .in_valid(iv[0]), .in_ready(irdy[0]),
    .op(logic_op_t'(opv[0])), .a(av[0][7:0]), .b(bv[0][7:0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .result(res0), .busy(bsy[0])
  );
  uop_logic_pipe #(.WIDTH(1), .LATENCY(1)) u_dut1 (
    .clk(clk), .n_reset(n_reset), .in_valid(iv[1]), .in_ready(irdy[1]),
    .op(logic_op_t'(opv[1])), .a(av[1][0:0]), .b(bv[1][0:0]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .result(res1), .busy(bsy[1])
  );
  uop_logic_pipe #(.WIDTH(64), .LATENCY(8)) u_dut2 (
    .clk(clk), .n_reset(n_reset), .in_valid(iv[2]), .in_ready(irdy[2]),
    .op(logic_op_t'(opv[2])), .a(av[2]), .b(bv[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .result(res2), .busy(bsy[2])
  );

  always_comb begin
    robs[0] = {56'b0, res0};
    robs[1] = {63'b0, res1};
    robs[2] = res2;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_op(logic [2:0] o, logic [63:0] x, logic [63:0] y,
                                         int unsigned w);
    logic [63:0] r;
    case (o)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: r = x ^ y;
      3'd3: r = ~(x & y);
      3'd4: r = ~(x | y);
      3'd5: r = ~(x ^ y);
      3'd6: r = x;
      default: r = ~x;
    endcase
    if (w < 64) r = r & ((64'd1 << w) - 64'd1);
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: retire before accept, since a retiring entry is still in the pipe.
  always @(negedge clk) begin : monitor
    ent_t e;
    for (int d = 0; d < 3; d++) begin
      if (!n_reset) begin
        sb[d].delete();
        prev_stall[d] = 1'b0;
      end else begin
        chk($sformatf("busy%0d", d), 64'(bsy[d]), 64'(sb[d].size() > 0));
        if (prev_stall[d]) begin
          chk($sformatf("hold_valid%0d", d), 64'(ov[d]), 64'd1);
          chk($sformatf("hold_result%0d", d), robs[d], prev_res[d]);
        end
        if (ov[d] && !ordy[d]) chk($sformatf("stall_in_ready%0d", d), 64'(irdy[d]), 64'd0);
        if (ov[d] && ordy[d]) begin
          if (sb[d].size() == 0) begin
            chk($sformatf("spurious_out%0d", d), 64'(ov[d]), 64'd0);
          end else begin
            e = sb[d].pop_front();
            chk($sformatf("result%0d", d), robs[d], e.res);
            if (e.exact) chk($sformatf("latency%0d", d), 64'(cyc - e.cyc), 64'(lat[d]));
          end
        end
        if (iv[d] && irdy[d]) begin
          e.res   = ref_op(opv[d], av[d], bv[d], wid[d]);
          e.cyc   = cyc;
          e.exact = exact_mode[d];
          sb[d].push_back(e);
        end
        prev_stall[d] = ov[d] && !ordy[d];
        prev_res[d]   = robs[d];
      end
    end
  end

  initial begin
    n_reset = 1'b0;
    iv = '0; ordy = '0; opv = '0; av = '0; bv = '0;
    exact_mode = '{0, 0, 0};
    #3;
    chk("rst_out_valid", 64'(ov[0]), 64'd0);
    chk("rst_result", robs[0], 64'd0);
    chk("rst_busy", 64'(bsy[0]), 64'd0);
    chk("rst_in_ready", 64'(irdy[0]), 64'd1);
    chk("rst_result_w64", robs[2], 64'd0);
    step();
    step();
    n_reset = 1'b1;
    step();

    // All opcodes on a=C5, b=3A, never stalled: exact latency checked.
    exact_mode[0] = 1'b1;
    ordy = 3'b111;
    for (int o = 0; o < 8; o++) begin
      iv[0] = 1'b1; opv[0] = 3'(o); av[0] = 64'hC5; bv[0] = 64'h3A;
      #1;
      chk("ops_in_ready", 64'(irdy[0]), 64'd1);
      step();
    end
    iv[0] = 1'b0;
    repeat (4) step();

    // Back-to-back XOR throughput.
    for (int i = 0; i < 16; i++) begin
      iv[0] = 1'b1; opv[0] = 3'd2;
      av[0] = 64'($urandom_range(0, 255)); bv[0] = 64'($urandom_range(0, 255));
      #1;
      chk("b2b_in_ready", 64'(irdy[0]), 64'd1);
      step();
    end
    iv[0] = 1'b0;
    repeat (4) step();
    chk("b2b_drained", 64'(sb[0].size()), 64'd0);
    exact_mode[0] = 1'b0;

    // Backpressure for 5 cycles while out_valid is high.
    iv[0] = 1'b1; opv[0] = 3'd0; av[0] = 64'hF3; bv[0] = 64'h5E;
    step();
    opv[0] = 3'd7; av[0] = 64'h81;
    step();
    ordy[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      opv[0] = 3'(i); av[0] = 64'($urandom_range(0, 255));
      #1;
      chk("bp_in_ready", 64'(irdy[0]), 64'd0);
      chk("bp_out_valid", 64'(ov[0]), 64'd1);
      step();
    end
    ordy[0] = 1'b1; iv[0] = 1'b0;
    repeat (6) step();
    chk("bp_drained", 64'(sb[0].size()), 64'd0);

    // Reset with two transactions in flight.
    iv[0] = 1'b1; opv[0] = 3'd1; av[0] = 64'h12; bv[0] = 64'h40;
    step();
    av[0] = 64'h77;
    step();
    iv[0] = 1'b0;
    chk("pre_rst_busy", 64'(bsy[0]), 64'd1);
    n_reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(ov[0]), 64'd0);
    chk("mid_rst_busy", 64'(bsy[0]), 64'd0);
    chk("mid_rst_result", robs[0], 64'd0);
    step();
    step();
    n_reset = 1'b1;
    repeat (6) step();
    chk("post_rst_out_valid", 64'(ov[0]), 64'd0);

    // Randomised traffic on all three configurations.
    for (int i = 0; i < 600; i++) begin
      for (int d = 0; d < 3; d++) begin
        iv[d]   = 1'($urandom_range(0, 1));
        opv[d]  = 3'($urandom_range(0, 7));
        av[d]   = {$urandom, $urandom};
        bv[d]   = {$urandom, $urandom};
        ordy[d] = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    iv = '0; ordy = 3'b111;
    repeat (12) step();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rand_drained%0d", d), 64'(sb[d].size()), 64'd0);
      chk($sformatf("rand_idle%0d", d), 64'(bsy[d]), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
